complex_div: RTL

Sequential complex divider for the receive equalizer path: computes q = a / b = a·conj(b) / |b|², scaled to a fixed-point output. It sits next to complex_mult in openofdm_rx and undoes a channel gain: the multiplier applies a gain, this block removes it. It uses a single shared restoring-division datapath with a ready/strobe handshake, and accepts one operand pair per division.

---
 rtl/complex_div.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/complex_div.sv
// rtl/complex_div.sv - sequential complex divider q = a*conj(b)/|b|^2 with shared restoring dividers (optional rounding: COMPLEX_DIV_ROUND_EN)
module complex_div #(
    parameter int IN_W      = 16,
    parameter int OUT_W     = 16,
    parameter int FRAC_BITS = 12
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic signed [IN_W-1:0]  a_i,
    input  logic signed [IN_W-1:0]  a_q,
    input  logic signed [IN_W-1:0]  b_i,
    input  logic signed [IN_W-1:0]  b_q,
    input  logic                    input_strobe,
    output logic                    input_ready,
    output logic signed [OUT_W-1:0] q_i,
    output logic signed [OUT_W-1:0] q_q,
    output logic                    output_strobe,
    output logic                    overflow,
    output logic                    div_by_zero
);

`ifdef COMPLEX_DIV_ROUND_EN
    localparam int RB = 1;
`else
    localparam int RB = 0;
`endif
    // K quotient bits; with rounding the last one is the half-LSB bit
    localparam int K  = OUT_W - 1 + RB;
    localparam int SH = FRAC_BITS + RB;
    localparam int PW = 2 * IN_W + 1;
    localparam int RW = PW + OUT_W + FRAC_BITS;
    localparam int CW = $clog2(K + 1);
    localparam logic [OUT_W-1:0] MAX_MAG = {1'b0, {(OUT_W-1){1'b1}}};

    typedef enum logic [2:0] {S_IDLE, S_MULT, S_NORM, S_DIV, S_OUT} state_t;

    state_t                 state;
    logic signed [IN_W-1:0] a_i_r, a_q_r, b_i_r, b_q_r;
    logic signed [PW-1:0]   n_i, n_q;
    logic [PW-1:0]          d;
    logic [RW-1:0]          rem_i, rem_q, dsh;
    logic [K-1:0]           qm_i, qm_q;
    logic                   neg_i, neg_q, sat_i, sat_q, dz;
    logic [CW-1:0]          cnt;
    logic                   strobe_r;

    // Sign-extended operands so products are formed at full precision
    logic signed [PW-1:0] ai_x, aq_x, bi_x, bq_x;
    assign ai_x = PW'(a_i_r);
    assign aq_x = PW'(a_q_r);
    assign bi_x = PW'(b_i_r);
    assign bq_x = PW'(b_q_r);

    // Magnitudes and the saturation pre-check used while in NORM
    logic [PW-1:0] mag_i_c, mag_q_c;
    logic [RW-1:0] mag_i_ext, mag_q_ext, d_ext, lim_c;
    logic          pre_sat_i, pre_sat_q;
    assign mag_i_c   = n_i[PW-1] ? -n_i : n_i;
    assign mag_q_c   = n_q[PW-1] ? -n_q : n_q;
    assign mag_i_ext = RW'(mag_i_c);
    assign mag_q_ext = RW'(mag_q_c);
    assign d_ext     = RW'(d);
    assign lim_c     = d_ext << (OUT_W - 1);
    assign pre_sat_i = (d != '0) && ((mag_i_ext << FRAC_BITS) >= lim_c);
    assign pre_sat_q = (d != '0) && ((mag_q_ext << FRAC_BITS) >= lim_c);

    // One restoring step per component: subtract the shifted divisor when it fits
    logic ge_i, ge_q;
    assign ge_i = rem_i >= dsh;
    assign ge_q = rem_q >= dsh;

    // Round (optional), saturate and apply sign; returns {overflow, value}
    function automatic logic [OUT_W:0] finish_comp(input logic [K-1:0] qm,
                                                   input logic neg,
                                                   input logic sat);
        logic [OUT_W-1:0] mag;
        logic             ovf;
`ifdef COMPLEX_DIV_ROUND_EN
        mag = OUT_W'(qm[K-1:1]) + OUT_W'(qm[0]);
`else
        mag = OUT_W'(qm);
`endif
        ovf = sat || (mag > MAX_MAG);
        if (ovf) mag = MAX_MAG;
        if (neg) mag = -mag;
        return {ovf, mag};
    endfunction

    logic [OUT_W-1:0] res_i_c, res_q_c;
    logic             ovf_i_c, ovf_q_c;
    assign {ovf_i_c, res_i_c} = finish_comp(qm_i, neg_i, sat_i);
    assign {ovf_q_c, res_q_c} = finish_comp(qm_q, neg_q, sat_q);

    assign input_ready   = (state == S_IDLE);
    // A pending pulse is held in strobe_r while frozen and shown once enable returns
    assign output_strobe = strobe_r & enable;

    // Control FSM and datapath; everything holds while enable is low
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= S_IDLE;
            a_i_r       <= '0;
            a_q_r       <= '0;
            b_i_r       <= '0;
            b_q_r       <= '0;
            n_i         <= '0;
            n_q         <= '0;
            d           <= '0;
            rem_i       <= '0;
            rem_q       <= '0;
            dsh         <= '0;
            qm_i        <= '0;
            qm_q        <= '0;
            neg_i       <= 1'b0;
            neg_q       <= 1'b0;
            sat_i       <= 1'b0;
            sat_q       <= 1'b0;
            dz          <= 1'b0;
            cnt         <= '0;
            strobe_r    <= 1'b0;
            q_i         <= '0;
            q_q         <= '0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (enable) begin
            strobe_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (input_strobe) begin
                        a_i_r <= a_i;
                        a_q_r <= a_q;
                        b_i_r <= b_i;
                        b_q_r <= b_q;
                        state <= S_MULT;
                    end
                end
                S_MULT: begin
                    n_i   <= ai_x * bi_x + aq_x * bq_x;
                    n_q   <= aq_x * bi_x - ai_x * bq_x;
                    d     <= bi_x * bi_x + bq_x * bq_x;
                    state <= S_NORM;
                end
                S_NORM: begin
                    neg_i <= n_i[PW-1];
                    neg_q <= n_q[PW-1];
                    sat_i <= pre_sat_i;
                    sat_q <= pre_sat_q;
                    dz    <= (d == '0);
                    rem_i <= mag_i_ext << SH;
                    rem_q <= mag_q_ext << SH;
                    dsh   <= d_ext << (K - 1);
                    cnt   <= '0;
                    state <= S_DIV;
                end
                S_DIV: begin
                    rem_i <= ge_i ? rem_i - dsh : rem_i;
                    rem_q <= ge_q ? rem_q - dsh : rem_q;
                    qm_i  <= {qm_i[K-2:0], ge_i};
                    qm_q  <= {qm_q[K-2:0], ge_q};
                    dsh   <= dsh >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(K - 1)) state <= S_OUT;
                end
                S_OUT: begin
                    q_i         <= dz ? '0 : res_i_c;
                    q_q         <= dz ? '0 : res_q_c;
                    overflow    <= !dz && (ovf_i_c || ovf_q_c);
                    div_by_zero <= dz;
                    strobe_r    <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
